// File: rtl/train_sequencer.sv
// rtl/train_sequencer.sv - op-code program sequencer driving the training controller
// Optional TRAIN_SEQ_WATCHDOG_EN: caps each EXEC line at 4*SIZE cycles without ctl_reset.
module train_sequencer #(
  parameter int OP_SIZE    = 4,
  parameter int SIZE       = 3,
  parameter int PROG_DEPTH = 16,
  parameter int EPOCHS     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [OP_SIZE-1:0]            prog_op,
  input  logic [$clog2(PROG_DEPTH):0]   prog_len,
  input  logic [31:0]                   epochs_in,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          ctl_reset,
  input  logic                          ctl_code_active,
  input  logic                          ctl_code_reset,
  output logic [OP_SIZE-1:0]            op,
  output logic [31:0]                   code_count,
  output logic [31:0]                   code_index,
  output logic                          enable,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [31:0]                   epoch_left
);
  localparam int AW = $clog2(PROG_DEPTH);
`ifdef TRAIN_SEQ_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT = 32'(4 * SIZE);
`endif

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d;
  logic [AW:0]         len_q, len_d;
  logic [OP_SIZE-1:0]  op_q, op_d;
  logic [31:0]         cc_q, cc_d;
  logic [31:0]         idx_q, idx_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [31:0]         ep_q, ep_d;

  logic [OP_SIZE-1:0]  mem [PROG_DEPTH];
  logic                mem_we;
  logic [AW:0]         pc_next;

  assign pc_next = {1'b0, pc_q} + {{AW{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    op_d    = op_q;
    cc_d    = cc_q;
    idx_d   = idx_q;
    en_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    ep_d    = ep_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_we = prog_we;
        if (start && !abort) begin
          if (prog_len == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            pc_d    = '0;
            err_d   = 1'b0;
            ep_d    = (epochs_in == 32'd0) ? 32'(EPOCHS) : epochs_in;
            len_d   = prog_len;
            busy_d  = 1'b1;
          end
        end
      end
      S_FETCH: begin
        op_d    = mem[pc_q];
        cc_d    = '0;
        idx_d   = 32'(pc_q);
        state_d = S_EXEC;
        en_d    = 1'b1;
        busy_d  = 1'b1;
      end
      S_EXEC: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        if (!ctl_reset) begin
`ifdef TRAIN_SEQ_WATCHDOG_EN
          if (cc_q == WD_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
            en_d    = 1'b0;
            busy_d  = 1'b0;
          end else begin
            cc_d = cc_q + 32'd1;
          end
`else
          cc_d = cc_q + 32'd1;
`endif
        end else if (ctl_code_reset) begin
          // code_reset outranks code_active: end of epoch
          en_d = 1'b0;
          if (ep_q == 32'd1) begin
            ep_d    = 32'd0;
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = !err_q;
          end else begin
            ep_d    = ep_q - 32'd1;
            pc_d    = '0;
            state_d = S_FETCH;
          end
        end else if (ctl_code_active) begin
          en_d = 1'b0;
          if (pc_next == len_q) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
            busy_d  = 1'b0;
          end else begin
            pc_d    = pc_next[AW-1:0];
            state_d = S_FETCH;
          end
        end else begin
          cc_d = '0;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      op_q    <= '0;
      cc_q    <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ep_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      op_q    <= op_d;
      cc_q    <= cc_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ep_q    <= ep_d;
    end
  end

  // program memory survives rst
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[prog_addr] <= prog_op;
    end
  end

  assign op         = op_q;
  assign code_count = cc_q;
  assign code_index = idx_q;
  assign enable     = en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign epoch_left = ep_q;

endmodule
